// File: rtl/aoc_mem_pkg.sv
// rtl/aoc_mem_pkg.sv - shared types and helpers for the memory-port arbiters
package aoc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    // Bits needed to index n items, never less than one so single-entry cases still get a port.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last winner
module rr_pick
    import aoc_mem_pkg::*;
#(
    parameter int N = 3
)
(
    input  logic [N-1:0]                req_vec,
    input  logic [clog2_min1(N)-1:0]    last,
    output logic                        found,
    output logic [clog2_min1(N)-1:0]    idx
);

    localparam int IW = clog2_min1(N);

    logic [IW-1:0] cand;

    // Scan last+1, last+2, ... modulo N so the previous winner is considered last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!found && req_vec[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - job-level round-robin owner of a single-port synchronous RAM
module mem_port_arbiter
    import aoc_mem_pkg::*;
#(
    parameter int N_CLIENTS = 3,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_HOLD  = 0
)
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_CLIENTS-1:0]                 req,
    output logic [N_CLIENTS-1:0]                 gnt,
    input  logic [N_CLIENTS*ADDR_W-1:0]          cl_addr,
    input  logic [N_CLIENTS*DATA_W-1:0]          cl_data_in,
    input  logic [N_CLIENTS-1:0]                 cl_we,
    output logic [DATA_W-1:0]                    cl_data_out,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [DATA_W-1:0]                    mem_data_in,
    output logic                                 mem_we,
    input  logic [DATA_W-1:0]                    mem_data_out,
    output logic [clog2_min1(N_CLIENTS)-1:0]     owner,
    output logic                                 busy,
    output logic                                 timeout_err
);

    localparam int OWNER_W = clog2_min1(N_CLIENTS);
    localparam int HOLD_W  = clog2_min1(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t             state_q, state_d;
    logic [N_CLIENTS-1:0]   gnt_q, gnt_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [N_CLIENTS-1:0]   lockout_q, lockout_d;
    logic                   tout_q, tout_d;

    logic [N_CLIENTS-1:0]   eligible;
    logic                   pick_found;
    logic [OWNER_W-1:0]     pick_idx;

    logic [ADDR_W-1:0]      addr_lane [N_CLIENTS];
    logic [DATA_W-1:0]      data_lane [N_CLIENTS];

    // A client that lost its grant to a timeout stays out until it drops its request.
    assign eligible = req & ~lockout_q;

    rr_pick #(.N(N_CLIENTS)) u_pick (
        .req_vec (eligible),
        .last    (owner_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Unpack the flat client buses into per-client lanes.
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            addr_lane[i] = cl_addr[i*ADDR_W +: ADDR_W];
            data_lane[i] = cl_data_in[i*DATA_W +: DATA_W];
        end
    end

    // Only the owner reaches the RAM, and only while the grant is live; otherwise drive zeros.
    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_we      = 1'b0;
        if (state_q == GRANT) begin
            mem_addr    = addr_lane[owner_q];
            mem_data_in = data_lane[owner_q];
            mem_we      = cl_we[owner_q];
        end
    end

    // Next-state logic: pick in IDLE, hold or revoke in GRANT, one turnaround cycle in RELEASE.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        tout_d    = tout_q;
        lockout_d = lockout_q & req;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    hold_d          = '0;
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = RELEASE;
                end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
                    gnt_d              = '0;
                    tout_d             = 1'b1;
                    lockout_d[owner_q] = 1'b1;
                    state_d            = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; owner resets to the last client so client 0 wins the first scan.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= OWNER_W'(N_CLIENTS - 1);
            hold_q    <= '0;
            lockout_q <= '0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            lockout_q <= lockout_d;
            tout_q    <= tout_d;
        end
    end

    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = tout_q;
    assign cl_data_out = mem_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;

    logic [2:0]  req,  req_b;
    logic [2:0]  gnt,  gnt_b;
    logic [95:0] cl_addr, cl_addr_b, cl_data_in, cl_data_in_b;
    logic [2:0]  cl_we, cl_we_b;
    logic [31:0] cl_data_out, cl_data_out_b;
    logic [31:0] mem_addr, mem_addr_b, mem_data_in, mem_data_in_b;
    logic        mem_we, mem_we_b;
    logic [31:0] mem_data_out, mem_data_out_b;
    logic [1:0]  owner, owner_b;
    logic        busy, busy_b, timeout_err, timeout_err_b;

    int vectors;
    int miscompares;
    int bad_writes;

    logic [31:0] ram [16];

    mem_port_arbiter #(.N_CLIENTS(3), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(0)) u_dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .cl_addr(cl_addr), .cl_data_in(cl_data_in), .cl_we(cl_we), .cl_data_out(cl_data_out),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_data_out(mem_data_out),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    mem_port_arbiter #(.N_CLIENTS(3), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(10)) u_dut_to (
        .clk(clk), .reset(reset), .req(req_b), .gnt(gnt_b),
        .cl_addr(cl_addr_b), .cl_data_in(cl_data_in_b), .cl_we(cl_we_b), .cl_data_out(cl_data_out_b),
        .mem_addr(mem_addr_b), .mem_data_in(mem_data_in_b), .mem_we(mem_we_b), .mem_data_out(mem_data_out_b),
        .owner(owner_b), .busy(busy_b), .timeout_err(timeout_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[3:0]] <= mem_data_in;
        mem_data_out <= ram[mem_addr[3:0]];
    end

    always @(posedge clk) begin
        if (mem_we && gnt == 3'b000) bad_writes <= bad_writes + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req   = 3'b111;
        repeat (3) tick;
        vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL rst_gnt: got %b want 000", gnt); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", mem_we); end
        vectors++; if (owner !== 2'd2) begin miscompares++; $display("FAIL rst_owner: got %0d want 2", owner); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_tout: got %b want 0", timeout_err); end
        vectors++; if (owner_b !== 2'd2 || gnt_b !== 3'b000) begin miscompares++; $display("FAIL rst_b: got owner %0d gnt %b want 2 000", owner_b, gnt_b); end
        reset = 1'b1;
        tick;
        vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL rst_first_gnt: got %b want 001", gnt); end
        vectors++; if (owner !== 2'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL rst_first_owner: got %0d/%b want 0/1", owner, busy); end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp;
        for (int g = 0; g < 4; g++) begin
            exp = 3'b001 << (g % 3);
            vectors++; if (gnt !== exp) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b want %b", g, gnt, exp); end
            vectors++; if (owner !== 2'(g % 3)) begin miscompares++; $display("FAIL rr_owner[%0d]: got %0d want %0d", g, owner, g % 3); end
            repeat (3) tick;
            vectors++; if (gnt !== exp) begin miscompares++; $display("FAIL rr_hold[%0d]: got %b want %b", g, gnt, exp); end
            if (g == 3) break;
            req[g % 3] = 1'b0;
            tick;
            vectors++; if (gnt !== 3'b000 || busy !== 1'b1) begin miscompares++; $display("FAIL rr_release[%0d]: got %b/%b want 000/1", g, gnt, busy); end
            req[g % 3] = 1'b1;
            tick;
            vectors++; if (gnt !== 3'b000 || busy !== 1'b0) begin miscompares++; $display("FAIL rr_idle[%0d]: got %b/%b want 000/0", g, gnt, busy); end
            tick;
        end
        req = 3'b000;
        tick;
        tick;
        vectors++; if (gnt !== 3'b000 || busy !== 1'b0) begin miscompares++; $display("FAIL rr_end: got %b/%b want 000/0", gnt, busy); end
    endtask

    task automatic test_isolation;
        cl_addr[0 +: 32] = 32'd5; cl_data_in[0 +: 32] = 32'h55; cl_we = 3'b001; req = 3'b001;
        #1;
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL iso_idle_we: got %b want 0", mem_we); end
        tick;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 32'd5) begin miscompares++; $display("FAIL iso_load: got we %b addr %0d want 1 5", mem_we, mem_addr); end
        tick;
        req = 3'b000; cl_we = 3'b000;
        tick;
        tick;
        cl_addr[0 +: 32] = 32'd5;  cl_data_in[0 +: 32]  = 32'hBAD;
        cl_addr[64 +: 32] = 32'd5; cl_data_in[64 +: 32] = 32'hBAD;
        cl_addr[32 +: 32] = 32'd7; cl_data_in[32 +: 32] = 32'hDEADBEEF;
        cl_we = 3'b111; req = 3'b010;
        #1;
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL iso_idle_we2: got %b want 0", mem_we); end
        tick;
        vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL iso_gnt: got %b want 010", gnt); end
        vectors++; if (mem_addr !== 32'd7 || mem_data_in !== 32'hDEADBEEF || mem_we !== 1'b1) begin miscompares++; $display("FAIL iso_mux: got %h/%h/%b want 7/deadbeef/1", mem_addr, mem_data_in, mem_we); end
        tick;
        cl_we = 3'b101;
        tick;
        vectors++; if (cl_data_out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL iso_readback: got %h want deadbeef", cl_data_out); end
        cl_addr[32 +: 32] = 32'd5;
        tick;
        vectors++; if (cl_data_out !== 32'h55) begin miscompares++; $display("FAIL iso_ram5: got %h want 55", cl_data_out); end
        req = 3'b000; cl_we = 3'b000;
        tick;
        tick;
    endtask

    task automatic test_sorter;
        logic [31:0] vals [8];
        logic [31:0] exp  [8];
        logic [31:0] buf_w [8];
        logic [31:0] t;
        vals = '{32'd5, 32'd3, 32'd9, 32'd1, 32'd7, 32'd2, 32'd8, 32'd4};
        exp  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7, 32'd8, 32'd9};
        req = 3'b001;
        tick;
        for (int i = 0; i < 8; i++) begin
            cl_addr[0 +: 32] = 32'(i); cl_data_in[0 +: 32] = vals[i]; cl_we = 3'b001;
            tick;
        end
        cl_we = 3'b000; req = 3'b000;
        tick;
        tick;
        req = 3'b010;
        tick;
        for (int i = 0; i < 8; i++) begin
            cl_addr[32 +: 32] = 32'(i);
            tick;
            buf_w[i] = cl_data_out;
        end
        vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL sort_owns: got %b want 010", gnt); end
        for (int a = 0; a < 7; a++) begin
            for (int b = 0; b < 7 - a; b++) begin
                if (buf_w[b] > buf_w[b+1]) begin
                    t = buf_w[b]; buf_w[b] = buf_w[b+1]; buf_w[b+1] = t;
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            cl_addr[32 +: 32] = 32'(i); cl_data_in[32 +: 32] = buf_w[i]; cl_we = 3'b010;
            tick;
        end
        cl_we = 3'b000; req = 3'b000;
        tick;
        vectors++; if (gnt !== 3'b000 || busy !== 1'b1) begin miscompares++; $display("FAIL sort_done: got %b/%b want 000/1", gnt, busy); end
        tick;
        for (int i = 0; i < 8; i++) begin
            vectors++; if (ram[i] !== exp[i]) begin miscompares++; $display("FAIL sort_ram[%0d]: got %0d want %0d", i, ram[i], exp[i]); end
        end
        vectors++; if (bad_writes !== 0) begin miscompares++; $display("FAIL ungranted_writes: got %0d want 0", bad_writes); end
    endtask

    task automatic test_timeout;
        req_b = 3'b100;
        tick;
        vectors++; if (gnt_b !== 3'b100) begin miscompares++; $display("FAIL to_gnt2: got %b want 100", gnt_b); end
        req_b = 3'b101;
        repeat (9) tick;
        vectors++; if (gnt_b !== 3'b100 || timeout_err_b !== 1'b0) begin miscompares++; $display("FAIL to_hold: got %b/%b want 100/0", gnt_b, timeout_err_b); end
        tick;
        vectors++; if (gnt_b !== 3'b000 || timeout_err_b !== 1'b1) begin miscompares++; $display("FAIL to_revoke: got %b/%b want 000/1", gnt_b, timeout_err_b); end
        tick;
        tick;
        vectors++; if (gnt_b !== 3'b001) begin miscompares++; $display("FAIL to_regrant0: got %b want 001", gnt_b); end
        req_b = 3'b100;
        repeat (3) tick;
        vectors++; if (gnt_b !== 3'b000) begin miscompares++; $display("FAIL to_locked: got %b want 000", gnt_b); end
        req_b = 3'b000;
        tick;
        req_b = 3'b100;
        tick;
        vectors++; if (gnt_b !== 3'b100 || timeout_err_b !== 1'b1) begin miscompares++; $display("FAIL to_regrant2: got %b/%b want 100/1", gnt_b, timeout_err_b); end
    endtask

    task automatic test_reset_mid_write;
        cl_addr_b[64 +: 32] = 32'd3; cl_data_in_b[64 +: 32] = 32'h1234; cl_we_b = 3'b100;
        #1;
        vectors++; if (mem_we_b !== 1'b1) begin miscompares++; $display("FAIL rmid_pre: got %b want 1", mem_we_b); end
        reset = 1'b0;
        tick;
        vectors++; if (mem_we_b !== 1'b0 || gnt_b !== 3'b000) begin miscompares++; $display("FAIL rmid_we: got %b/%b want 0/000", mem_we_b, gnt_b); end
        vectors++; if (busy_b !== 1'b0 || timeout_err_b !== 1'b0) begin miscompares++; $display("FAIL rmid_state: got busy %b tout %b want 0 0", busy_b, timeout_err_b); end
        vectors++; if (owner_b !== 2'd2) begin miscompares++; $display("FAIL rmid_owner: got %0d want 2", owner_b); end
        tick;
        vectors++; if (mem_we_b !== 1'b0) begin miscompares++; $display("FAIL rmid_hold: got %b want 0", mem_we_b); end
        reset = 1'b1; req_b = 3'b000; cl_we_b = 3'b000;
        tick;
    endtask

    initial begin
        vectors = 0; miscompares = 0; bad_writes = 0;
        reset = 1'b0;
        req = '0; cl_addr = '0; cl_data_in = '0; cl_we = '0;
        req_b = '0; cl_addr_b = '0; cl_data_in_b = '0; cl_we_b = '0;
        mem_data_out_b = '0;
        test_reset;
        test_round_robin;
        test_isolation;
        test_sorter;
        test_timeout;
        test_reset_mid_write;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
